// File: rtl/write_pointer_full.sv
// Write-side pointer and full/overflow logic for an asynchronous FIFO.
// Define WRITE_LEVEL_EN to compile in occupancy reporting (write_level, write_almost_full).
module write_pointer_full #(
  parameter int ADDR_WIDTH         = 6,
  parameter int ALMOST_FULL_THRESH = 56
) (
  input  logic                  clock_write,
  input  logic                  write_reset_n,
  input  logic                  write_en,
  input  logic                  clear_overflow,
  input  logic [ADDR_WIDTH:0]   sync_read_pointer,
  output logic [ADDR_WIDTH:0]   write_pointer,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic                  write_mem_en,
  output logic                  write_full,
  output logic                  write_overflow,
  output logic [ADDR_WIDTH:0]   write_level,
  output logic                  write_almost_full
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] full_pattern;
  logic          accept;
  logic          full_next;

  // Reset gating keeps the RAM strobe quiet while write_full is being cleared.
  assign accept       = write_en & ~write_full & write_reset_n;
  assign write_mem_en = accept;

  assign wbin_next  = wbin + {{(PW-1){1'b0}}, accept};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Full when the writer is exactly one lap ahead: Gray MSB pair inverted, rest equal.
  assign full_pattern = {~sync_read_pointer[PW-1:PW-2], sync_read_pointer[PW-3:0]};
  assign full_next    = (wgray_next == full_pattern);

  always_ff @(posedge clock_write or negedge write_reset_n) begin
    if (!write_reset_n) begin
      wbin          <= '0;
      write_pointer <= '0;
      write_full    <= 1'b0;
    end else begin
      wbin          <= wbin_next;
      write_pointer <= wgray_next;
      write_full    <= full_next;
    end
  end

  assign write_address = wbin[ADDR_WIDTH-1:0];

  // Sticky overflow: a rejected write outranks a same-cycle clear.
  always_ff @(posedge clock_write or negedge write_reset_n) begin
    if (!write_reset_n) begin
      write_overflow <= 1'b0;
    end else if (write_en && write_full) begin
      write_overflow <= 1'b1;
    end else if (clear_overflow) begin
      write_overflow <= 1'b0;
    end
  end

`ifdef WRITE_LEVEL_EN
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;

  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(sync_read_pointer >> i);
    end
  end

  assign level_next = wbin_next - rbin;

  always_ff @(posedge clock_write or negedge write_reset_n) begin
    if (!write_reset_n) begin
      write_level       <= '0;
      write_almost_full <= 1'b0;
    end else begin
      write_level       <= level_next;
      write_almost_full <= (level_next >= PW'(ALMOST_FULL_THRESH));
    end
  end
`else
  assign write_level       = '0;
  assign write_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_write_pointer_full.sv
// Directed and randomized bench for write_pointer_full against an occupancy-count model.
// Honours WRITE_LEVEL_EN for the level/almost-full expectations.
module tb_write_pointer_full;

  logic       clock_write = 1'b0;
  logic       write_reset_n = 1'b0;
  logic       write_en = 1'b0;
  logic       clear_overflow = 1'b0;
  logic [6:0] sync_read_pointer = '0;
  logic [6:0] write_pointer;
  logic [5:0] write_address;
  logic       write_mem_en;
  logic       write_full;
  logic       write_overflow;
  logic [6:0] write_level;
  logic       write_almost_full;

  int checks = 0;
  int failures = 0;

  // Model state: total writes and reads as 7-bit lap counters.
  logic [6:0] wcnt = '0;
  logic [6:0] rcnt = '0;
  logic       mFull = 1'b0;
  logic       mOvf = 1'b0;
  logic [6:0] mLevel = '0;
  logic       mAlmost = 1'b0;

  write_pointer_full dut (
    .clock_write       (clock_write),
    .write_reset_n     (write_reset_n),
    .write_en          (write_en),
    .clear_overflow    (clear_overflow),
    .sync_read_pointer (sync_read_pointer),
    .write_pointer     (write_pointer),
    .write_address     (write_address),
    .write_mem_en      (write_mem_en),
    .write_full        (write_full),
    .write_overflow    (write_overflow),
    .write_level       (write_level),
    .write_almost_full (write_almost_full)
  );

  always #5 clock_write = ~clock_write;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [6:0] toGray(input logic [6:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRegs();
    check("write_pointer", 32'(write_pointer), 32'(toGray(wcnt)));
    check("write_address", 32'(write_address), 32'(wcnt % 64));
    check("write_full", 32'(write_full), 32'(mFull));
    check("write_overflow", 32'(write_overflow), 32'(mOvf));
    check("write_level", 32'(write_level), 32'(mLevel));
    check("write_almost_full", 32'(write_almost_full), 32'(mAlmost));
  endtask

  // One clock: drive at negedge, check strobe before the edge, registers after.
  task automatic step(input bit we, input bit clr);
    logic       acc;
    logic [6:0] occ;
    @(negedge clock_write);
    write_en          = we;
    clear_overflow    = clr;
    sync_read_pointer = toGray(rcnt);
    #1;
    acc = we && !mFull;
    check("write_mem_en", 32'(write_mem_en), 32'(acc));
    check("addr_before_edge", 32'(write_address), 32'(wcnt % 64));
    @(posedge clock_write);
    #1;
    if (we && mFull) mOvf = 1'b1;
    else if (clr)    mOvf = 1'b0;
    wcnt  = wcnt + 7'(acc);
    occ   = wcnt - rcnt;
    mFull = (occ == 7'd64);
`ifdef WRITE_LEVEL_EN
    mLevel  = occ;
    mAlmost = (occ >= 7'd56);
`else
    mLevel  = '0;
    mAlmost = 1'b0;
`endif
    checkRegs();
  endtask

  task automatic modelReset();
    wcnt = '0; rcnt = '0; mFull = 1'b0; mOvf = 1'b0; mLevel = '0; mAlmost = 1'b0;
  endtask

  // Asynchronous reset mid-cycle with a write still requested.
  task automatic asyncReset();
    @(posedge clock_write);
    #3;
    write_en = 1'b1;
    write_reset_n = 1'b0;
    #1;
    modelReset();
    check("rst_mem_en", 32'(write_mem_en), 32'd0);
    checkRegs();
    @(posedge clock_write);
    @(negedge clock_write);
    write_en = 1'b0;
    clear_overflow = 1'b0;
    sync_read_pointer = '0;
    write_reset_n = 1'b1;
  endtask

  initial begin
    logic [6:0] occNow;
    int         adv;
    $display("[TB] start");
    // Reset state.
    #12;
    modelReset();
    checkRegs();
    check("reset_mem_en", 32'(write_mem_en), 32'd0);
    @(negedge clock_write);
    write_reset_n = 1'b1;

    // 64 writes with the reader parked at 0: fills the FIFO.
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0);
    check("full_after_64", 32'(write_full), 32'd1);
    check("ptr_after_64", 32'(write_pointer), 32'h60);

    // Writes while full: rejected, overflow set, clear, set-beats-clear.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("ovf_set", 32'(write_overflow), 32'd1);
    step(1'b0, 1'b1);
    check("ovf_cleared", 32'(write_overflow), 32'd0);
    step(1'b1, 1'b1);
    check("ovf_set_wins", 32'(write_overflow), 32'd1);
    step(1'b0, 1'b1);

    // Reader advances by one: full drops, one write refills at address 0.
    rcnt = 7'd1;
    step(1'b0, 1'b0);
    check("full_released", 32'(write_full), 32'd0);
    step(1'b1, 1'b0);
    check("full_again", 32'(write_full), 32'd1);

    // Wrap: reader trails by two so the FIFO never fills across 127 -> 0.
    rcnt = wcnt - 7'd2;
    step(1'b0, 1'b0);
    for (int i = 0; i < 130; i++) begin
      rcnt = wcnt - 7'd2;
      step(1'b1, 1'b0);
      check("wrap_no_full", 32'(write_full), 32'd0);
      if (wcnt == 7'd127) check("gray_127", 32'(write_pointer), 32'h40);
      if (wcnt == 7'd0)   check("gray_wrap_0", 32'(write_pointer), 32'h00);
    end

    // Reset mid-burst after 20 writes.
    asyncReset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    asyncReset();
    step(1'b1, 1'b0);
    check("post_reset_addr", 32'(write_address), 32'd1);

    // Occupancy threshold: 56 outstanding, then reader takes one.
    asyncReset();
    for (int i = 0; i < 56; i++) step(1'b1, 1'b0);
`ifdef WRITE_LEVEL_EN
    check("level_56", 32'(write_level), 32'd56);
    check("almost_56", 32'(write_almost_full), 32'd1);
`endif
    rcnt = 7'd1;
    step(1'b0, 1'b0);
`ifdef WRITE_LEVEL_EN
    check("level_55", 32'(write_level), 32'd55);
    check("almost_55", 32'(write_almost_full), 32'd0);
`endif

    // Randomized producer/consumer traffic, reader jumps by 0..occupancy.
    for (int i = 0; i < 400; i++) begin
      occNow = wcnt - rcnt;
      adv = 0;
      if (($urandom % 3) == 0) adv = $urandom_range(0, int'(occNow));
      rcnt = rcnt + 7'(adv);
      step(($urandom % 4) != 0, ($urandom % 8) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
